// File: rtl/dma_mem_slave.sv
// Byte-wide memory slave on the DMAC bus: decodes MEMR/MEMW, stretches each
// access by WS wait states via RDY, and flags out-of-range or dual-strobe accesses.
module dma_mem_slave #(
  parameter int unsigned DEPTH   = 256,
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [7:0]  RD_MISS = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEMR,
  input  logic        MEMW,
  input  logic [15:0] Addrbus,
  input  logic [7:0]  Wdata,
  output logic [7:0]  Rdata,
  output logic        RDY,
  input  logic [2:0]  WS,
  output logic        ERR,
  input  logic        ERR_CLR
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     rdata_q;
  logic           rdy_q;
  logic           err_q;
  logic [7:0]     mem_q [DEPTH];

  logic           strobe_s;
  logic           start_s;
  logic           commit_s;
  logic [15:0]    c_addr_s;
  logic [7:0]     c_wdata_s;
  logic           c_rd_s;
  logic           c_wr_s;
  logic           hit_s;
  logic           proto_s;
  logic [AW-1:0]  off_s;

  // Address decode in 17 bits so BASE+DEPTH may reach 16'hFFFF+1.
  function automatic logic addr_hit(input logic [15:0] a);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, BASE};
    hi = lo + 17'(DEPTH);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  // Next-state logic: access start, wait countdown and commit strobe.
  always_comb begin
    strobe_s = MEMR | MEMW;
    start_s  = strobe_s && ((state_q == S_IDLE) ||
                            ((state_q == S_DONE) && (Addrbus != addr_q)));
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    if (start_s) begin
      addr_d  = Addrbus;
      wdata_d = Wdata;
      rd_d    = MEMR;
      wr_d    = MEMW;
      if (WS == 3'd0) begin
        state_d  = S_DONE;
        commit_s = 1'b1;
      end else begin
        state_d = S_WAIT;
        cnt_d   = WS;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_d  = S_DONE;
            commit_s = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_DONE: begin
          if (strobe_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A zero-wait access commits on its sampling edge, so it uses the live bus.
  assign c_addr_s  = start_s ? Addrbus : addr_q;
  assign c_wdata_s = start_s ? Wdata   : wdata_q;
  assign c_rd_s    = start_s ? MEMR    : rd_q;
  assign c_wr_s    = start_s ? MEMW    : wr_q;
  assign hit_s     = addr_hit(c_addr_s);
  assign proto_s   = c_rd_s & c_wr_s;
  assign off_s     = AW'(c_addr_s - BASE);

  // State, latched access, read data, ready and sticky error registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 3'd0;
      rdata_q <= 8'h00;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d != S_WAIT);
      if (commit_s && c_rd_s && !c_wr_s) begin
        rdata_q <= hit_s ? mem_q[off_s] : RD_MISS;
      end
      if (commit_s && (proto_s || !hit_s)) begin
        err_q <= 1'b1;
      end else if (ERR_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  // Storage array; contents survive reset by design.
  always_ff @(posedge CLK) begin
    if (commit_s && c_wr_s && !c_rd_s && hit_s) begin
      mem_q[off_s] <= c_wdata_s;
    end
  end

  assign Rdata = rdata_q;
  assign RDY   = rdy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_dma_mem_slave.sv
// Self-checking bench for dma_mem_slave: directed vector table, burst and
// reset corner cases, then random accesses against a memory-array model.
module tb_dma_mem_slave;

  localparam int DEPTH_P = 256;
  localparam int BASE_P  = 0;

  logic        CLK;
  logic        RST_N;
  logic        MEMR;
  logic        MEMW;
  logic [15:0] Addrbus;
  logic [7:0]  Wdata;
  logic [7:0]  Rdata;
  logic        RDY;
  logic [2:0]  WS;
  logic        ERR;
  logic        ERR_CLR;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        clr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [2:0]  ws;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lows;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] bexp [3];
  logic [7:0] mem_m [DEPTH_P];
  logic [7:0] rdata_m;
  logic       err_m;

  dma_mem_slave #(.DEPTH(256), .BASE(16'h0000), .RD_MISS(8'hFF)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEMR(MEMR), .MEMW(MEMW), .Addrbus(Addrbus),
    .Wdata(Wdata), .Rdata(Rdata), .RDY(RDY), .WS(WS), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rd, input logic wr, input logic clr,
                              input logic [15:0] a, input logic [7:0] d, input logic [2:0] ws,
                              input logic [7:0] er, input logic ee, input int el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.clr = clr; v.addr = a; v.wd = d; v.ws = ws;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lows = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left on a falling edge with the slave idle.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input logic [2:0] ws, input logic clr_dur,
                           output int lows, output logic [7:0] rdo, output logic erro);
    MEMR = rd; MEMW = wr; Addrbus = a; Wdata = d; WS = ws; ERR_CLR = clr_dur;
    lows = 0;
    @(posedge CLK);
    @(negedge CLK);
    while (RDY !== 1'b1 && lows < 20) begin
      lows++;
      WS = 3'($urandom);
      @(negedge CLK);
    end
    rdo = Rdata;
    erro = ERR;
    MEMR = 1'b0; MEMW = 1'b0; ERR_CLR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic clr_pulse();
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
  endtask

  initial begin
    int         lows;
    logic [7:0] rdo;
    logic       erro;
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  ws;
    logic        rd, wr, clr, hit, efl;
    int          ai, kind;

    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 16'h0050, 8'h0A, 3'd0, 8'h00, 1'b0, 0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 16'h0050, 8'h00, 3'd0, 8'h0A, 1'b0, 0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 16'h00A4, 8'h05, 3'd2, 8'h0A, 1'b0, 2);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 16'h00A4, 8'h00, 3'd3, 8'h05, 1'b0, 3);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 16'h00A5, 8'h0A, 3'd0, 8'h05, 1'b0, 0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 16'h00A6, 8'h0F, 3'd7, 8'h05, 1'b0, 7);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0150, 8'h00, 3'd1, 8'hFF, 1'b1, 1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 16'h0150, 8'h99, 3'd0, 8'hFF, 1'b1, 0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 16'h00A6, 8'h00, 3'd0, 8'h0F, 1'b0, 0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 16'h0010, 8'h33, 3'd0, 8'h0F, 1'b0, 0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 16'h0010, 8'h77, 3'd2, 8'h0F, 1'b1, 2);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, 3'd1, 8'h33, 1'b0, 1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 3'd0, 8'hFF, 1'b1, 0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 16'h00FF, 8'hC3, 3'd4, 8'hFF, 1'b0, 4);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 16'h00FF, 8'h00, 3'd0, 8'hC3, 1'b0, 0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 3'd2, 8'hFF, 1'b1, 2);
    bexp[0] = 8'h05; bexp[1] = 8'h0A; bexp[2] = 8'h0F;

    MEMR = 1'b0; MEMW = 1'b0; Addrbus = 16'h0000; Wdata = 8'h00; WS = 3'd0; ERR_CLR = 1'b0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("reset_rdy", RDY, 1'b1);
    chk("reset_rdata", Rdata, 8'h00);
    chk("reset_err", ERR, 1'b0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_reset_rdy", RDY, 1'b1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].clr) clr_pulse();
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].ws, 1'b0, lows, rdo, erro);
      chk($sformatf("vec%0d_rdy_low_cycles", i), lows, tbl[i].exp_lows);
      chk($sformatf("vec%0d_rdata", i), rdo, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), erro, tbl[i].exp_err);
    end

    // Burst: MEMR held, address steps once RDY returns high
    clr_pulse();
    MEMR = 1'b1; Addrbus = 16'h00A4; WS = 3'd1;
    for (int b = 0; b < 3; b++) begin
      @(posedge CLK);
      lows = 0;
      @(negedge CLK);
      while (RDY !== 1'b1 && lows < 20) begin
        lows++;
        @(negedge CLK);
      end
      chk($sformatf("burst%0d_rdy_low_cycles", b), lows, 1);
      chk($sformatf("burst%0d_rdata", b), Rdata, bexp[b]);
      if (b < 2) Addrbus = Addrbus + 16'd1;
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge CLK);
      chk($sformatf("burst_hold%0d_no_repeat", h), RDY, 1'b1);
    end
    chk("burst_err", ERR, 1'b0);
    MEMR = 1'b0;
    @(negedge CLK);

    // Reset during the third wait cycle of a write discards it
    do_access(1'b0, 1'b1, 16'h0020, 8'h11, 3'd0, 1'b0, lows, rdo, erro);
    do_access(1'b1, 1'b0, 16'h0150, 8'h00, 3'd0, 1'b0, lows, rdo, erro);
    chk("pre_rst_err", erro, 1'b1);
    MEMW = 1'b1; Addrbus = 16'h0020; Wdata = 8'h55; WS = 3'd5;
    @(posedge CLK);
    repeat (3) @(negedge CLK);
    chk("mid_wait_rdy", RDY, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("async_rst_rdy", RDY, 1'b1);
    chk("async_rst_rdata", Rdata, 8'h00);
    chk("async_rst_err", ERR, 1'b0);
    MEMW = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    do_access(1'b1, 1'b0, 16'h0020, 8'h00, 3'd0, 1'b0, lows, rdo, erro);
    chk("rst_discard_rdata", rdo, 8'h11);
    chk("rst_discard_err", erro, 1'b0);
    rdata_m = 8'h11;
    err_m = 1'b0;

    // Random phase against the memory-array model
    for (int i = 0; i < DEPTH_P; i++) begin
      d = 8'($urandom);
      do_access(1'b0, 1'b1, 16'(BASE_P + i), d, 3'd0, 1'b0, lows, rdo, erro);
      mem_m[i] = d;
    end
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 7);
      rd = (kind == 0) || (kind >= 4);
      wr = (kind <= 3);
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(256, 65535));
      else a = 16'($urandom_range(0, 255));
      d = 8'($urandom);
      ws = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 3) == 0);
      ai = int'(a);
      hit = (ai >= BASE_P) && (ai < BASE_P + DEPTH_P);
      efl = (rd && wr) || !hit;
      if (!(rd && wr)) begin
        if (wr && hit) mem_m[ai - BASE_P] = d;
        else if (rd) rdata_m = hit ? mem_m[ai - BASE_P] : 8'hFF;
      end
      err_m = clr ? efl : (err_m | efl);
      do_access(rd, wr, a, d, ws, clr, lows, rdo, erro);
      chk($sformatf("rnd%0d_rdy_low_cycles", n), lows, int'(ws));
      chk($sformatf("rnd%0d_rdata a=%0h", n, a), rdo, rdata_m);
      chk($sformatf("rnd%0d_err", n), erro, err_m);
    end

    // Out-of-range write must leave every location untouched
    do_access(1'b0, 1'b1, 16'h0150, 8'h5A, 3'd2, 1'b0, lows, rdo, erro);
    chk("oor_write_err", erro, 1'b1);
    for (int i = 0; i < DEPTH_P; i++) begin
      do_access(1'b1, 1'b0, 16'(BASE_P + i), 8'h00, 3'd0, 1'b0, lows, rdo, erro);
      chk($sformatf("scan_%0d", i), rdo, mem_m[i]);
    end
    chk("err_sticky", ERR, 1'b1);
    clr_pulse();
    chk("err_clr", ERR, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
